// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell stepped LSB to MSB, with valid/ready on both sides.
// Define SERIAL_ADDER_OVERFLOW_EN to add the signed-overflow output ovf.

module full_adder (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = in1 ^ in2 ^ cin;
    assign cout = (in1 & in2) | (cin & (in1 ^ in2));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [WIDTH:0]   res_nx;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum, fa_cout;
    logic             last;

    full_adder u_fa (
        .in1  (a_sh[0]),
        .in2  (b_sh[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last   = (cnt == LAST);
    // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at res_sh[0].
    assign res_nx = {fa_sum, res_sh};
    assign sum    = res_sh;
    assign cout   = carry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh    <= a;
                    b_sh    <= b;
                    carry_q <= cin;
                    cnt     <= '0;
                end
                RUN: begin
                    res_sh  <= res_nx[WIDTH:1];
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_cout;
                    if (!last) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ovf_q <= 1'b0;
        else if (state == RUN && last) ovf_q <= carry_q ^ fa_cout;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 1, cout, busy;
    logic [7:0] a = 0, b = 0, sum;
    logic       in_valid1 = 0, in_ready1, cin1 = 0, out_valid1, out_ready1 = 1, cout1, busy1;
    logic [0:0] a1 = 0, b1 = 0, sum1;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic ovf, ovf1;
`endif

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );

    int compared   = 0;
    int mismatched = 0;
    logic [9:0] q8[$];   // {ovf, cout, sum}
    logic [2:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the scoreboard on every output handshake.
    always @(negedge clk) if (!rst) begin
        logic [9:0] e;
        check("excl8", {31'b0, in_ready && out_valid}, 32'd0);
        if (out_valid && out_ready) begin
            if (q8.size() == 0) check("unexpected8", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("sum8", {24'b0, sum}, {24'b0, e[7:0]});
                check("cout8", {31'b0, cout}, {31'b0, e[8]});
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("ovf8", {31'b0, ovf}, {31'b0, e[9]});
`endif
            end
        end
    end

    always @(negedge clk) if (!rst) begin
        logic [2:0] e;
        check("excl1", {31'b0, in_ready1 && out_valid1}, 32'd0);
        if (out_valid1 && out_ready1) begin
            if (q1.size() == 0) check("unexpected1", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("sum1", {31'b0, sum1}, {31'b0, e[0]});
                check("cout1", {31'b0, cout1}, {31'b0, e[1]});
`ifdef SERIAL_ADDER_OVERFLOW_EN
                check("ovf1", {31'b0, ovf1}, {31'b0, e[2]});
`endif
            end
        end
    end

    task automatic issue8(input logic [7:0] va, vb, input logic vc, input logic [9:0] exp, input bit push);
        int n = 0;
        in_valid = 1; a = va; b = vb; cin = vc;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) check("accept8_timeout", 32'd1, 32'd0);
        if (push) q8.push_back(exp);
        tick();
        in_valid = 0;
    endtask

    task automatic wait_out8(input int lat_exp);
        int lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        check("lat8", lat, lat_exp);
    endtask

    task automatic issue1(input logic va, vb, vc, input logic [2:0] exp);
        int n = 0;
        in_valid1 = 1; a1 = va; b1 = vb; cin1 = vc;
        while (!in_ready1 && n < 50) begin tick(); n++; end
        if (!in_ready1) check("accept1_timeout", 32'd1, 32'd0);
        q1.push_back(exp);
        tick();
        in_valid1 = 0;
        n = 0;
        while (!out_valid1 && n < 50) begin tick(); n++; end
        check("lat1", n, 1);
        tick();
    endtask

    initial begin
        time t1, t2;
        int  n;
        repeat (2) tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_sum", {24'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_in_ready1", {31'b0, in_ready1}, 32'd1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst = 0;
        tick();

        // Basic vectors
        issue8(8'h5A, 8'h33, 1'b0, {1'b1, 1'b0, 8'h8D}, 1); wait_out8(8); tick();
        issue8(8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'h00}, 1); wait_out8(8); tick();

        // Backpressure
        out_ready = 0;
        issue8(8'h12, 8'h34, 1'b1, {1'b0, 1'b0, 8'h47}, 1); wait_out8(8);
        repeat (5) begin
            @(negedge clk);
            check("bp_sum", {24'b0, sum}, 32'h47);
            check("bp_cout", {31'b0, cout}, 32'd0);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1;
        tick();
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

        // Back-to-back with in_valid held; operands change during RUN
        in_valid = 1; a = 8'd3; b = 8'd4; cin = 0;
        q8.push_back({1'b0, 1'b0, 8'd7});
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tick(); t1 = $time;
        a = 8'd100; b = 8'd200; cin = 1;
        q8.push_back({1'b0, 1'b1, 8'd45});
        wait_out8(8);
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        tick(); t2 = $time;
        in_valid = 0;
        check("b2b_interval", 32'((t2 - t1) / 10), 32'd10);
        wait_out8(8); tick();

        // Reset mid-RUN discards the operation
        issue8(8'h11, 8'h22, 1'b0, 10'd0, 0);
        repeat (2) tick();
        rst = 1; #1;
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_sum", {24'b0, sum}, 32'd0);
        tick(); #2; rst = 0;
        repeat (12) tick();
        check("post_rst_no_out", {31'b0, out_valid}, 32'd0);
        issue8(8'd1, 8'd1, 1'b0, {1'b0, 1'b0, 8'd2}, 1); wait_out8(8); tick();

        // WIDTH=1
        issue1(1'b1, 1'b1, 1'b1, 3'b011);
        issue1(1'b0, 1'b1, 1'b0, 3'b001);

        repeat (3) tick();
        check("q8_drained", q8.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
